// File: rtl/mips_funct_pkg.sv
// Shared MIPS R-type funct codes, write-back source selects and the
// result selector's state encoding.
package mips_funct_pkg;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_HILO = 1'b1
    } state_t;

    // Which bus feeds the register-file write port; SRC_NONE means no write-back.
    typedef enum logic [2:0] {
        SRC_ALU   = 3'd0,
        SRC_SHIFT = 3'd1,
        SRC_HI    = 3'd2,
        SRC_LO    = 3'd3,
        SRC_NONE  = 3'd4
    } src_t;

    typedef struct packed {
        src_t src;
        logic legal;
    } dec_t;

endpackage

// File: rtl/result_select_reg.sv
// Registered write-back result selector: picks ALU/shifter/HI/LO by funct,
// registers it with a one-cycle valid pulse, and stalls MFHI/MFLO behind an
// in-flight divide with a bounded wait.
module result_select_reg
    import mips_funct_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FUNCT_W  = 6,
    parameter int WAIT_MAX = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [WIDTH-1:0]   shift_out,
    input  logic [WIDTH-1:0]   hi_out,
    input  logic [WIDTH-1:0]   lo_out,
    input  logic               hilo_busy,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    output logic               err
);

    localparam int CNT_W = $clog2(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state;
    logic             sel_hi;
    logic [CNT_W-1:0] wait_cnt;
    dec_t             dec;
    logic             accept;

    // DIVU is legal but writes nothing back; unknown codes are illegal.
    function automatic dec_t decode(input logic [FUNCT_W-1:0] f);
        dec_t d;
        d.src   = SRC_NONE;
        d.legal = 1'b1;
        case (f)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: d.src = SRC_ALU;
            F_SRL:                            d.src = SRC_SHIFT;
            F_MFHI:                           d.src = SRC_HI;
            F_MFLO:                           d.src = SRC_LO;
            F_DIVU:                           d.src = SRC_NONE;
            default:                          d.legal = 1'b0;
        endcase
        return d;
    endfunction

    assign dec      = decode(funct);
    assign op_ready = (state == IDLE);
    assign accept   = op_valid && op_ready;

    // Capture the selected source, or park in WAIT_HILO until HI/LO settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_hi     <= 1'b0;
            wait_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (dec.src)
                            SRC_ALU: begin
                                data_out   <= alu_out;
                                data_valid <= 1'b1;
                            end
                            SRC_SHIFT: begin
                                data_out   <= shift_out;
                                data_valid <= 1'b1;
                            end
                            SRC_HI, SRC_LO: begin
                                if (hilo_busy) begin
                                    state    <= WAIT_HILO;
                                    sel_hi   <= (dec.src == SRC_HI);
                                    wait_cnt <= '0;
                                end else begin
                                    data_out   <= (dec.src == SRC_HI) ? hi_out : lo_out;
                                    data_valid <= 1'b1;
                                end
                            end
                            default: err <= !dec.legal;
                        endcase
                    end
                end
                WAIT_HILO: begin
                    // A settled divider wins over a timeout landing the same cycle.
                    if (!hilo_busy) begin
                        data_out   <= sel_hi ? hi_out : lo_out;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        data_out   <= '0;
                        data_valid <= 1'b1;
                        err        <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_select_reg.sv
// Directed bench for result_select_reg. dut_a uses the default WAIT_MAX,
// dut_b uses WAIT_MAX=4 for the timeout scenario; both share stimulus.
module tb_result_select_reg;
    import mips_funct_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] alu_out, shift_out, hi_out, lo_out;
    logic        hilo_busy;

    logic        ready_a, dv_a, err_a;
    logic [31:0] out_a;
    logic        ready_b, dv_b, err_b;
    logic [31:0] out_b;

    int n_cmp = 0;
    int n_bad = 0;

    result_select_reg #(.WIDTH(32), .FUNCT_W(6), .WAIT_MAX(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(ready_a),
        .funct(funct), .alu_out(alu_out), .shift_out(shift_out),
        .hi_out(hi_out), .lo_out(lo_out), .hilo_busy(hilo_busy),
        .data_out(out_a), .data_valid(dv_a), .err(err_a)
    );

    result_select_reg #(.WIDTH(32), .FUNCT_W(6), .WAIT_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(ready_b),
        .funct(funct), .alu_out(alu_out), .shift_out(shift_out),
        .hi_out(hi_out), .lo_out(lo_out), .hilo_busy(hilo_busy),
        .data_out(out_b), .data_valid(dv_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; funct = '0; alu_out = '0; shift_out = '0;
        hi_out = '0; lo_out = '0; hilo_busy = 1'b0;
        #12;
        n_cmp++; if (out_a !== 32'h0) begin n_bad++; $display("FAIL reset_data_out got=%h exp=%h", out_a, 32'h0); end
        n_cmp++; if (dv_a !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid got=%b exp=0", dv_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_a); end
        n_cmp++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin n_bad++; $display("FAIL reset_op_ready got=%b%b exp=11", ready_a, ready_b); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        funct = F_ADD; alu_out = 32'h0000_0005; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        n_cmp++; if (out_a !== 32'h5 || dv_a !== 1'b1 || err_a !== 1'b0) begin n_bad++; $display("FAIL add_capture got out=%h dv=%b err=%b exp out=00000005 dv=1 err=0", out_a, dv_a, err_a); end
        tick();
        n_cmp++; if (out_a !== 32'h5 || dv_a !== 1'b0) begin n_bad++; $display("FAIL add_hold got out=%h dv=%b exp out=00000005 dv=0", out_a, dv_a); end
    endtask

    task automatic test_back_to_back();
        funct = F_SRL; shift_out = 32'h8000_0000; op_valid = 1'b1;
        tick();
        n_cmp++; if (out_a !== 32'h8000_0000 || dv_a !== 1'b1) begin n_bad++; $display("FAIL b2b_srl got out=%h dv=%b exp out=80000000 dv=1", out_a, dv_a); end
        funct = F_OR; alu_out = 32'h0F0F_0F0F;
        tick();
        op_valid = 1'b0;
        n_cmp++; if (out_a !== 32'h0F0F_0F0F || dv_a !== 1'b1) begin n_bad++; $display("FAIL b2b_or got out=%h dv=%b exp out=0f0f0f0f dv=1", out_a, dv_a); end
        tick();
        n_cmp++; if (dv_a !== 1'b0 || out_a !== 32'h0F0F_0F0F) begin n_bad++; $display("FAIL b2b_idle got out=%h dv=%b exp out=0f0f0f0f dv=0", out_a, dv_a); end
    endtask

    task automatic test_hilo_wait();
        funct = F_MFLO; lo_out = 32'h7; hilo_busy = 1'b1; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ready_a !== 1'b0 || dv_a !== 1'b0) begin n_bad++; $display("FAIL wait_stall[%0d] got ready=%b dv=%b exp ready=0 dv=0", i, ready_a, dv_a); end
            if (i < 4) tick();
        end
        hilo_busy = 1'b0;
        tick();
        n_cmp++; if (out_a !== 32'h7 || dv_a !== 1'b1 || err_a !== 1'b0) begin n_bad++; $display("FAIL wait_release got out=%h dv=%b err=%b exp out=00000007 dv=1 err=0", out_a, dv_a, err_a); end
        n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL wait_ready got=%b exp=1", ready_a); end
    endtask

    task automatic test_timeout();
        pulse_reset();
        funct = F_MFHI; hi_out = 32'hDEAD_BEEF; hilo_busy = 1'b1; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        n_cmp++; if (ready_b !== 1'b0) begin n_bad++; $display("FAIL to_enter got ready=%b exp=0", ready_b); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++; if (err_b !== 1'b0 || dv_b !== 1'b0 || ready_b !== 1'b0) begin n_bad++; $display("FAIL to_early[%0d] got err=%b dv=%b ready=%b exp 0 0 0", i, err_b, dv_b, ready_b); end
        end
        tick();
        n_cmp++; if (err_b !== 1'b1 || dv_b !== 1'b1 || out_b !== 32'h0) begin n_bad++; $display("FAIL to_fire got err=%b dv=%b out=%h exp err=1 dv=1 out=00000000", err_b, dv_b, out_b); end
        n_cmp++; if (ready_b !== 1'b1) begin n_bad++; $display("FAIL to_ready got=%b exp=1", ready_b); end
        hilo_busy = 1'b0;
        tick();
        n_cmp++; if (err_b !== 1'b0 || dv_b !== 1'b0) begin n_bad++; $display("FAIL to_after got err=%b dv=%b exp 0 0", err_b, dv_b); end
    endtask

    task automatic test_illegal_divu();
        funct = F_ADD; alu_out = 32'h1111_2222; op_valid = 1'b1;
        tick();
        funct = 6'b111111;
        tick();
        n_cmp++; if (err_a !== 1'b1 || dv_a !== 1'b0 || out_a !== 32'h1111_2222) begin n_bad++; $display("FAIL illegal got err=%b dv=%b out=%h exp err=1 dv=0 out=11112222", err_a, dv_a, out_a); end
        funct = F_DIVU;
        tick();
        op_valid = 1'b0;
        n_cmp++; if (err_a !== 1'b0 || dv_a !== 1'b0 || out_a !== 32'h1111_2222) begin n_bad++; $display("FAIL divu got err=%b dv=%b out=%h exp err=0 dv=0 out=11112222", err_a, dv_a, out_a); end
        tick();
        n_cmp++; if (err_a !== 1'b0 || out_a !== 32'h1111_2222) begin n_bad++; $display("FAIL divu_after got err=%b out=%h exp err=0 out=11112222", err_a, out_a); end
    endtask

    task automatic test_reset_mid_wait();
        funct = F_ADD; alu_out = 32'h0000_ABCD; op_valid = 1'b1;
        tick();
        funct = F_MFLO; lo_out = 32'h9; hilo_busy = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        n_cmp++; if (ready_a !== 1'b0 || out_a !== 32'h0000_ABCD) begin n_bad++; $display("FAIL rmw_pre got ready=%b out=%h exp ready=0 out=0000abcd", ready_a, out_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_a !== 32'h0 || dv_a !== 1'b0 || err_a !== 1'b0 || ready_a !== 1'b1) begin n_bad++; $display("FAIL rmw_async got out=%h dv=%b err=%b ready=%b exp 00000000 0 0 1", out_a, dv_a, err_a, ready_a); end
        #10;
        rst_n = 1'b1;
        hilo_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (dv_a !== 1'b0 || out_a !== 32'h0 || ready_a !== 1'b1) begin n_bad++; $display("FAIL rmw_dropped[%0d] got dv=%b out=%h ready=%b exp 0 00000000 1", i, dv_a, out_a, ready_a); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_hilo_wait();
        test_timeout();
        test_illegal_divu();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
